ex_wb_ctrl: RTL and testbench

- Sequencing controller for the EX/WB pipeline buffer.
- Decides each cycle whether the buffer captures, holds, or captures a bubble.
- Mirrors the buffered control bits (valid, regWrite, memRead, rd) and gates the register-file write enable.
- Stalls upstream stages on load-use hazards and while a memory read is outstanding; sits between hazard/branch logic and the writeback port.

---
 rtl/ex_wb_ctrl_pkg.sv | 14 +
 rtl/ex_wb_ctrl_if.sv | 32 +++
 rtl/hazard_cmp.sv | 21 ++
 rtl/ex_wb_ctrl.sv | 125 ++++++++++++
 tb/tb_ex_wb_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_wb_ctrl_pkg.sv
// rtl/ex_wb_ctrl_pkg.sv - shared pipeline control types and constants for the EX/WB controller
package ex_wb_ctrl_pkg;

    localparam int RD_W = 6;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/ex_wb_ctrl_if.sv
// rtl/ex_wb_ctrl_if.sv - EX/WB controller bus: pipeline inputs and buffer/writeback controls
interface ex_wb_ctrl_if #(
    parameter int RD_W = 6
);
    import ex_wb_ctrl_pkg::*;

    logic            ex_valid;
    logic            ex_regWrite;
    logic            ex_memRead;
    logic [RD_W-1:0] ex_rd;
    logic [RD_W-1:0] id_rs;
    logic [RD_W-1:0] id_rt;
    logic            flush;
    logic            mem_ready;
    logic            buf_load;
    logic            buf_bubble;
    logic            stall_id;
    logic            wb_en;
    logic            wb_sel_mem;
    logic            err_timeout;

    modport master (
        output ex_valid, ex_regWrite, ex_memRead, ex_rd, id_rs, id_rt, flush, mem_ready,
        input  buf_load, buf_bubble, stall_id, wb_en, wb_sel_mem, err_timeout
    );

    modport slave (
        input  ex_valid, ex_regWrite, ex_memRead, ex_rd, id_rs, id_rt, flush, mem_ready,
        output buf_load, buf_bubble, stall_id, wb_en, wb_sel_mem, err_timeout
    );

endinterface

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational rd vs rs/rt match; ZERO_REG_PROTECT_EN masks rd==0
module hazard_cmp #(
    parameter int RD_W = 6
) (
    input  logic [RD_W-1:0] i_rd,
    input  logic [RD_W-1:0] i_rs,
    input  logic [RD_W-1:0] i_rt,
    output logic            o_match
);

    logic w_rd_live;

`ifdef ZERO_REG_PROTECT_EN
    assign w_rd_live = |i_rd;
`else
    assign w_rd_live = 1'b1;
`endif

    assign o_match = w_rd_live & ((i_rd == i_rs) | (i_rd == i_rt));

endmodule

// File: rtl/ex_wb_ctrl.sv
// rtl/ex_wb_ctrl.sv - EX/WB buffer sequencing, load-use/memory stalls, writeback gating (ZERO_REG_PROTECT_EN)
module ex_wb_ctrl #(
    parameter int RD_W        = 6,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    ex_wb_ctrl_if.slave bus
);
    import ex_wb_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

    state_t          r_state;
    logic            r_buf_valid;
    logic            r_buf_regwrite;
    logic            r_buf_memread;
    logic [RD_W-1:0] r_buf_rd;
    logic [CNT_W-1:0] r_wait_cnt;
    logic            r_flush_pend;
    logic            r_err_timeout;

    logic w_rs_rt_hit;
    logic w_load_use;
    logic w_wb_rd_live;
    logic w_buf_load;
    logic w_buf_bubble;
    logic w_stall_id;
    logic w_wb_en;
    logic w_wb_sel;

    hazard_cmp #(.RD_W(RD_W)) u_hazard_cmp (
        .i_rd    (bus.ex_rd),
        .i_rs    (bus.id_rs),
        .i_rt    (bus.id_rt),
        .o_match (w_rs_rt_hit)
    );

    assign w_load_use = bus.ex_valid & bus.ex_memRead & bus.ex_regWrite & w_rs_rt_hit;

`ifdef ZERO_REG_PROTECT_EN
    assign w_wb_rd_live = |r_buf_rd;
`else
    // r0 writes pass through; the register file discards them
    logic w_unused_buf_rd;
    assign w_unused_buf_rd = ^r_buf_rd;
    assign w_wb_rd_live    = 1'b1;
`endif

    always_comb begin
        w_buf_load   = 1'b0;
        w_buf_bubble = 1'b0;
        w_stall_id   = 1'b0;
        w_wb_en      = 1'b0;
        w_wb_sel     = WB_SEL_ALU;
        if (reset_n) begin
            case (r_state)
                RUN: begin
                    // a load-use stall keeps the load flowing; only ID/EX is frozen
                    w_buf_load   = 1'b1;
                    w_buf_bubble = !bus.ex_valid | bus.flush | r_flush_pend;
                    w_stall_id   = w_load_use;
                    w_wb_en      = r_buf_valid & r_buf_regwrite & !r_buf_memread & w_wb_rd_live;
                end
                MEM_WAIT: begin
                    w_buf_bubble = 1'b1;
                    w_stall_id   = 1'b1;
                    w_wb_sel     = WB_SEL_MEM;
                    w_wb_en      = bus.mem_ready & r_buf_regwrite & w_wb_rd_live;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state        <= RUN;
            r_buf_valid    <= 1'b0;
            r_buf_regwrite <= 1'b0;
            r_buf_memread  <= 1'b0;
            r_buf_rd       <= '0;
            r_wait_cnt     <= '0;
            r_flush_pend   <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_buf_valid    <= !w_buf_bubble;
                    r_buf_regwrite <= bus.ex_regWrite & !w_buf_bubble;
                    r_buf_memread  <= bus.ex_memRead & !w_buf_bubble;
                    r_buf_rd       <= bus.ex_rd;
                    r_flush_pend   <= 1'b0;
                    r_wait_cnt     <= '0;
                    if (bus.ex_memRead && !w_buf_bubble) begin
                        r_state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    r_wait_cnt   <= r_wait_cnt + 1'b1;
                    r_flush_pend <= r_flush_pend | bus.flush;
                    // mem_ready wins over the timeout in the final wait cycle
                    if (bus.mem_ready) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= RUN;
                    end else if (r_wait_cnt == LAST_WAIT) begin
                        r_buf_valid   <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_state       <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.buf_load    = w_buf_load;
    assign bus.buf_bubble  = w_buf_bubble;
    assign bus.stall_id    = w_stall_id;
    assign bus.wb_en       = w_wb_en;
    assign bus.wb_sel_mem  = w_wb_sel;
    assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ex_wb_ctrl.sv
// tb/tb_ex_wb_ctrl.sv - directed self-checking bench for ex_wb_ctrl
module tb_ex_wb_ctrl;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;

`ifdef ZERO_REG_PROTECT_EN
    localparam logic EXP_R0 = 1'b0;
`else
    localparam logic EXP_R0 = 1'b1;
`endif

    ex_wb_ctrl_if #(.RD_W(6)) bus ();

    ex_wb_ctrl #(.RD_W(6), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clock);
    endtask

    task automatic set_ex(input logic v, input logic rw, input logic mr, input logic [5:0] rd);
        bus.ex_valid    = v;
        bus.ex_regWrite = rw;
        bus.ex_memRead  = mr;
        bus.ex_rd       = rd;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset_n       = 1'b0;
        bus.id_rs     = 6'd62;
        bus.id_rt     = 6'd63;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        set_ex(1, 1, 0, 5);

        // reset: outputs forced low
        tick;
        tick;
        at_neg;
        chk("rst_load", bus.buf_load, 1'b0);
        chk("rst_bubble", bus.buf_bubble, 1'b0);
        chk("rst_stall", bus.stall_id, 1'b0);
        chk("rst_wb_en", bus.wb_en, 1'b0);
        chk("rst_sel", bus.wb_sel_mem, 1'b0);
        chk("rst_err", bus.err_timeout, 1'b0);

        // ALU op rd=5 captured, written next cycle
        tick;
        reset_n = 1'b1;
        at_neg;
        chk("alu_load", bus.buf_load, 1'b1);
        chk("alu_bubble", bus.buf_bubble, 1'b0);
        chk("alu_wb_en_pre", bus.wb_en, 1'b0);
        tick;
        set_ex(0, 0, 0, 0);
        at_neg;
        chk("alu_wb_en", bus.wb_en, 1'b1);
        chk("alu_sel", bus.wb_sel_mem, 1'b0);
        chk("alu_stall", bus.stall_id, 1'b0);
        chk("idle_bubble", bus.buf_bubble, 1'b1);

        // load-use: rd=7 vs rt=8 then rt=7
        tick;
        set_ex(1, 1, 1, 7);
        bus.id_rt = 6'd8;
        at_neg;
        chk("lu_nohit_stall", bus.stall_id, 1'b0);
        chk("lu_nohit_bubble", bus.buf_bubble, 1'b0);
        chk("lu_wb_en_after_idle", bus.wb_en, 1'b0);
        #1;
        bus.id_rt = 6'd7;
        #2;
        chk("lu_hit_stall", bus.stall_id, 1'b1);
        chk("lu_hit_bubble", bus.buf_bubble, 1'b0);
        chk("lu_hit_load", bus.buf_load, 1'b1);

        // load waits, mem_ready in the third wait cycle
        tick;
        bus.id_rt = 6'd63;
        set_ex(1, 1, 0, 9);
        at_neg;
        chk("mw1_stall", bus.stall_id, 1'b1);
        chk("mw1_load", bus.buf_load, 1'b0);
        chk("mw1_sel", bus.wb_sel_mem, 1'b1);
        chk("mw1_wb_en", bus.wb_en, 1'b0);
        tick;
        at_neg;
        chk("mw2_stall", bus.stall_id, 1'b1);
        chk("mw2_load", bus.buf_load, 1'b0);
        chk("mw2_wb_en", bus.wb_en, 1'b0);
        tick;
        bus.mem_ready = 1'b1;
        at_neg;
        chk("mw3_wb_en", bus.wb_en, 1'b1);
        chk("mw3_sel", bus.wb_sel_mem, 1'b1);
        chk("mw3_stall", bus.stall_id, 1'b1);
        chk("mw3_load", bus.buf_load, 1'b0);
        tick;
        bus.mem_ready = 1'b0;
        at_neg;
        chk("post_ld_stall", bus.stall_id, 1'b0);
        chk("post_ld_load", bus.buf_load, 1'b1);
        chk("post_ld_bubble", bus.buf_bubble, 1'b0);
        chk("post_ld_wb_en", bus.wb_en, 1'b0);
        chk("post_ld_sel", bus.wb_sel_mem, 1'b0);

        // flush during MEM_WAIT squashes first capture after return
        tick;
        set_ex(1, 1, 1, 10);
        at_neg;
        chk("rd9_wb_en", bus.wb_en, 1'b1);
        tick;
        bus.flush = 1'b1;
        set_ex(1, 1, 0, 11);
        at_neg;
        chk("fl_mw_load", bus.buf_load, 1'b0);
        chk("fl_mw_wb_en", bus.wb_en, 1'b0);
        tick;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b1;
        at_neg;
        chk("fl_mw_ready_wb_en", bus.wb_en, 1'b1);
        tick;
        bus.mem_ready = 1'b0;
        at_neg;
        chk("fl_pend_bubble", bus.buf_bubble, 1'b1);
        chk("fl_pend_load", bus.buf_load, 1'b1);
        chk("fl_pend_stall", bus.stall_id, 1'b0);
        tick;
        set_ex(1, 1, 0, 12);
        at_neg;
        chk("fl_pend_cleared", bus.buf_bubble, 1'b0);
        chk("fl_squashed_wb_en", bus.wb_en, 1'b0);

        // flush with a load in RUN: bubble, no MEM_WAIT
        tick;
        set_ex(1, 1, 1, 13);
        bus.flush = 1'b1;
        at_neg;
        chk("rd12_wb_en", bus.wb_en, 1'b1);
        chk("fl_ld_bubble", bus.buf_bubble, 1'b1);
        tick;
        bus.flush = 1'b0;
        set_ex(1, 1, 1, 14);
        at_neg;
        chk("fl_ld_stall", bus.stall_id, 1'b0);
        chk("fl_ld_load", bus.buf_load, 1'b1);
        chk("fl_ld_wb_en", bus.wb_en, 1'b0);

        // timeout: 16 wait cycles without mem_ready
        tick;
        set_ex(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            at_neg;
            chk("to_wb_en", bus.wb_en, 1'b0);
            chk("to_stall", bus.stall_id, 1'b1);
            if (i == 15) chk("to_err_before", bus.err_timeout, 1'b0);
            tick;
        end
        set_ex(1, 1, 1, 15);
        at_neg;
        chk("to_run_stall", bus.stall_id, 1'b0);
        chk("to_run_load", bus.buf_load, 1'b1);
        chk("to_err", bus.err_timeout, 1'b1);
        chk("to_run_wb_en", bus.wb_en, 1'b0);

        // mem_ready in the final wait cycle wins over timeout
        tick;
        set_ex(0, 0, 0, 0);
        for (int i = 0; i < 15; i++) begin
            at_neg;
            chk("late_wb_en", bus.wb_en, 1'b0);
            tick;
        end
        bus.mem_ready = 1'b1;
        at_neg;
        chk("late_ready_wb_en", bus.wb_en, 1'b1);
        chk("err_sticky", bus.err_timeout, 1'b1);
        tick;
        bus.mem_ready = 1'b0;

        // reset mid-MEM_WAIT abandons the load and clears the error
        set_ex(1, 1, 1, 16);
        at_neg;
        chk("rm_run_stall", bus.stall_id, 1'b0);
        tick;
        set_ex(0, 0, 0, 0);
        at_neg;
        chk("rm_wait_stall", bus.stall_id, 1'b1);
        tick;
        reset_n = 1'b0;
        at_neg;
        chk("rm_rst_load", bus.buf_load, 1'b0);
        chk("rm_rst_stall", bus.stall_id, 1'b0);
        chk("rm_rst_wb_en", bus.wb_en, 1'b0);
        chk("rm_rst_sel", bus.wb_sel_mem, 1'b0);
        chk("rm_rst_bubble", bus.buf_bubble, 1'b0);
        tick;
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        at_neg;
        chk("rm_err_cleared", bus.err_timeout, 1'b0);
        chk("rm_stall", bus.stall_id, 1'b0);
        chk("rm_wb_en", bus.wb_en, 1'b0);
        chk("rm_load", bus.buf_load, 1'b1);
        chk("rm_sel", bus.wb_sel_mem, 1'b0);
        tick;
        bus.mem_ready = 1'b0;

        // register zero handling
        set_ex(1, 1, 0, 0);
        tick;
        set_ex(1, 1, 1, 0);
        bus.id_rs = 6'd0;
        at_neg;
        chk("r0_alu_wb_en", bus.wb_en, EXP_R0);
        chk("r0_lu_stall", bus.stall_id, EXP_R0);
        tick;
        bus.id_rs     = 6'd62;
        set_ex(0, 0, 0, 0);
        bus.mem_ready = 1'b1;
        at_neg;
        chk("r0_ld_stall", bus.stall_id, 1'b1);
        chk("r0_ld_wb_en", bus.wb_en, EXP_R0);
        tick;
        bus.mem_ready = 1'b0;
        at_neg;
        chk("r0_ld_done_stall", bus.stall_id, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
